// File: rtl/axis_router_pkg.sv
// Shared definitions for the packet-aware AXI-Stream router.
//   state_e   : packet FSM states (IDLE, ROUTE, DROP)
//   SEL_BASE  : offset between a sel code and its channel index
//   sel_valid : true when a sel code addresses an existing channel
package axis_router_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_e;

    // sel == SEL_BASE addresses channel 0; sel == 0 is reserved as "no channel".
    localparam int SEL_BASE = 1;

    function automatic logic sel_valid(input int sel, input int n_ch);
        return (sel >= SEL_BASE) && (sel < SEL_BASE + n_ch);
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register tagged with a destination channel.
// A beat may be loaded and the held beat unloaded in the same cycle, so a
// stream sustains one beat per cycle while the consumer is ready.
//   clk, rst    : clock, synchronous active-high reset
//   in_load     : load in_data/in_last/in_ch (only when in_ready is high)
//   in_ready    : register is empty or is being unloaded this cycle
//   out_ready   : the addressed consumer accepts the held beat
//   out_valid   : register holds a beat
//   out_data    : held data
//   out_last    : held beat ends a packet
//   out_ch      : channel index the held beat is addressed to
module axis_out_reg #(
    parameter int DATA_W = 8,
    parameter int CH_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [CH_W-1:0]   in_ch,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [CH_W-1:0]   out_ch
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              last_q,  last_d;
    logic [CH_W-1:0]   ch_q,    ch_d;

    assign in_ready = !valid_q || out_ready;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        ch_d    = ch_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        // A load in the same cycle as an unload wins; contents only change
        // when empty or draining, which keeps a stalled beat stable.
        if (in_load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            last_d  = in_last;
            ch_d    = in_ch;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            // NOTE: the payload is reset as well as the valid bit so the outputs
            // are fully defined from the first cycle after reset.
            data_q  <= '0;
            last_q  <= 1'b0;
            ch_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_ch    = ch_q;

endmodule

// File: rtl/axis_pkt_router.sv
// Packet-aware AXI-Stream router: steers one input stream to one of N_CH
// output channels. The channel is taken from sel on the first beat of each
// packet and held until tlast; packets with an invalid sel are swallowed.
//   clk, rst  : clock, synchronous active-high reset
//   sel       : channel select, 1..N_CH -> channel sel-1, others invalid
//   s_tdata, s_tvalid, s_tlast, s_tready : input stream
//   m_tdata   : per-channel data, channel i at [i*DATA_W +: DATA_W]
//   m_tvalid, m_tlast, m_tready          : per-channel handshake
//   busy      : a packet is open (ROUTE or DROP)
//   drop_pkt  : one-cycle pulse after the last beat of a dropped packet
module axis_pkt_router
    import axis_router_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_CH   = 5,
    parameter int SEL_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SEL_W-1:0]         sel,
    input  logic [DATA_W-1:0]        s_tdata,
    input  logic                     s_tvalid,
    input  logic                     s_tlast,
    output logic                     s_tready,
    output logic [N_CH*DATA_W-1:0]   m_tdata,
    output logic [N_CH-1:0]          m_tvalid,
    output logic [N_CH-1:0]          m_tlast,
    input  logic [N_CH-1:0]          m_tready,
    output logic                     busy,
    output logic                     drop_pkt
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic              drop_pkt_q, drop_pkt_d;

    logic              s_accept;
    logic              sel_ok;
    logic [CH_W-1:0]   sel_ch;
    logic              load;
    logic [CH_W-1:0]   load_ch;
    logic              reg_in_ready;
    logic              reg_valid;
    logic [DATA_W-1:0] reg_data;
    logic              reg_last;
    logic [CH_W-1:0]   reg_ch;
    logic              ch_ready;

    assign sel_ok = sel_valid(int'(sel), N_CH);
    assign sel_ch = CH_W'(int'(sel) - SEL_BASE);

    // DROP never needs the output register, so it keeps the input flowing
    // even while a routed beat is still stalled on its channel.
    assign s_tready = !rst && ((state_q == DROP) || reg_in_ready);
    assign s_accept = s_tvalid && s_tready;

    always_comb begin
        state_d    = state_q;
        cur_ch_d   = cur_ch_q;
        drop_pkt_d = 1'b0;
        load       = 1'b0;
        load_ch    = cur_ch_q;
        case (state_q)
            IDLE: begin
                if (s_accept) begin
                    if (sel_ok) begin
                        load     = 1'b1;
                        load_ch  = sel_ch;
                        cur_ch_d = sel_ch;
                        if (!s_tlast) begin
                            state_d = ROUTE;
                        end
                    end else if (s_tlast) begin
                        drop_pkt_d = 1'b1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            ROUTE: begin
                if (s_accept) begin
                    load = 1'b1;
                    if (s_tlast) begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (s_accept && s_tlast) begin
                    state_d    = IDLE;
                    drop_pkt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_ch_q   <= '0;
            drop_pkt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_ch_q   <= cur_ch_d;
            drop_pkt_q <= drop_pkt_d;
        end
    end

    axis_out_reg #(
        .DATA_W (DATA_W),
        .CH_W   (CH_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .in_load   (load),
        .in_data   (s_tdata),
        .in_last   (s_tlast),
        .in_ch     (load_ch),
        .in_ready  (reg_in_ready),
        .out_ready (ch_ready),
        .out_valid (reg_valid),
        .out_data  (reg_data),
        .out_last  (reg_last),
        .out_ch    (reg_ch)
    );

    // Fan the single register out to the addressed channel; every other
    // channel (and all channels while empty) sees zeros. Only the addressed
    // channel's tready can drain the register.
    always_comb begin
        m_tdata  = '0;
        m_tvalid = '0;
        m_tlast  = '0;
        ch_ready = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (reg_ch == CH_W'(i)) begin
                ch_ready = m_tready[i];
                if (reg_valid) begin
                    m_tvalid[i]                   = 1'b1;
                    m_tlast[i]                    = reg_last;
                    m_tdata[i*DATA_W +: DATA_W]   = reg_data;
                end
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign drop_pkt = drop_pkt_q;

endmodule

// File: tb/tb_axis_pkt_router.sv
// Self-checking bench for axis_pkt_router. Packets are driven with random or
// directed content; a scoreboard derives each packet's destination from the
// sel seen on its first beat and checks per-channel ordering, latency, hold
// stability under backpressure, busy/drop_pkt behaviour and reset.
module tb_axis_pkt_router;

    localparam int DATA_W = 8;
    localparam int N_CH   = 5;
    localparam int SEL_W  = 3;

    typedef logic [DATA_W:0] beat_t;   // {last, data}

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [SEL_W-1:0]       sel = '0;
    logic [DATA_W-1:0]      s_tdata = '0;
    logic                   s_tvalid = 1'b0;
    logic                   s_tlast = 1'b0;
    logic                   s_tready;
    logic [N_CH*DATA_W-1:0] m_tdata;
    logic [N_CH-1:0]        m_tvalid;
    logic [N_CH-1:0]        m_tlast;
    logic [N_CH-1:0]        m_tready;
    logic                   busy;
    logic                   drop_pkt;

    logic [N_CH-1:0]        rand_rdy  = '1;
    logic [N_CH-1:0]        hold_mask = '0;
    bit                     rdy_random = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    int cur_dest = -1;
    int stalls = 0;
    int exp_drop_total = 0;
    int obs_drops = 0;

    always #5 clk = ~clk;

    assign m_tready = (rdy_random ? rand_rdy : '1) & ~hold_mask;

    always @(posedge clk) begin
        #1 rand_rdy = N_CH'($urandom) | N_CH'($urandom);
    end

    axis_pkt_router #(
        .DATA_W (DATA_W),
        .N_CH   (N_CH),
        .SEL_W  (SEL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .busy     (busy),
        .drop_pkt (drop_pkt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    beat_t             exp_q[N_CH][$];
    bit                exp_busy = 1'b0;
    bit                exp_drop_mode = 1'b0;
    bit                exp_drop = 1'b0;
    bit                pend_v = 1'b0;
    int                pend_ch = 0;
    beat_t             pend_beat = '0;
    bit                rst_seen = 1'b0;
    logic [N_CH-1:0]   prev_stall = '0;
    logic [DATA_W-1:0] prev_data[N_CH];
    logic              prev_last[N_CH];

    always @(negedge clk) begin
        logic [DATA_W-1:0] d;
        beat_t             e;
        bit                hs;
        bit                exp_rdy;
        if (rst) begin
            check("rst_s_tready", s_tready, 0);
            if (rst_seen) begin
                check("rst_m_tvalid", m_tvalid, 0);
                check("rst_m_tlast", m_tlast, 0);
                check("rst_m_tdata", m_tdata, 0);
                check("rst_busy", busy, 0);
                check("rst_drop_pkt", drop_pkt, 0);
            end
            rst_seen = 1'b1;
            for (int i = 0; i < N_CH; i++) exp_q[i].delete();
            exp_busy = 1'b0;
            exp_drop_mode = 1'b0;
            exp_drop = 1'b0;
            pend_v = 1'b0;
            prev_stall = '0;
        end else begin
            rst_seen = 1'b0;
            // A beat accepted at the previous edge must be on its channel now.
            if (pend_v) begin
                check("lat_valid", m_tvalid[pend_ch], 1);
                check("lat_data", m_tdata[pend_ch*DATA_W +: DATA_W], pend_beat[DATA_W-1:0]);
                check("lat_last", m_tlast[pend_ch], pend_beat[DATA_W]);
            end
            check("onehot_valid", ($countones(m_tvalid) <= 1), 1);
            for (int i = 0; i < N_CH; i++) begin
                d = m_tdata[i*DATA_W +: DATA_W];
                if (prev_stall[i]) begin
                    check("hold_valid", m_tvalid[i], 1);
                    check("hold_data", d, prev_data[i]);
                    check("hold_last", m_tlast[i], prev_last[i]);
                end
                if (!m_tvalid[i]) begin
                    check("idle_data", d, 0);
                    check("idle_last", m_tlast[i], 0);
                end
                if (m_tvalid[i] && m_tready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check("unexpected_beat_ch", i, 99);
                    end else begin
                        e = exp_q[i].pop_front();
                        check("out_data", d, e[DATA_W-1:0]);
                        check("out_last", m_tlast[i], e[DATA_W]);
                    end
                end
                prev_stall[i] = m_tvalid[i] && !m_tready[i];
                prev_data[i]  = d;
                prev_last[i]  = m_tlast[i];
            end
            check("busy", busy, exp_busy);
            check("drop_pkt", drop_pkt, exp_drop);
            if (drop_pkt) obs_drops++;
            // Inside a dropped packet input is always accepted; otherwise the
            // input waits only on a stalled beat still held for its channel.
            exp_rdy = (exp_busy && exp_drop_mode) ? 1'b1
                    : ((m_tvalid == '0) || ((m_tvalid & m_tready) != '0));
            check("s_tready", s_tready, exp_rdy);

            hs = s_tvalid && s_tready;
            exp_drop = hs && s_tlast && (exp_busy ? exp_drop_mode : (cur_dest < 0));
            pend_v = hs && (cur_dest >= 0);
            pend_ch = (cur_dest >= 0) ? cur_dest : 0;
            pend_beat = {s_tlast, s_tdata};
            if (hs && cur_dest >= 0) exp_q[cur_dest].push_back({s_tlast, s_tdata});
            if (hs) begin
                if (!exp_busy) exp_drop_mode = (cur_dest < 0);
                exp_busy = !s_tlast;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] data, input bit last, input int sel_v);
        int waits;
        s_tvalid = 1'b1;
        s_tdata  = data;
        s_tlast  = last;
        sel      = SEL_W'(sel_v);
        waits    = 0;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            stalls++;
            waits++;
            if (waits > 200) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // sel_mid < 0 randomises sel on later beats; abort_after > 0 stops the
    // packet after that many beats without sending tlast.
    task automatic send_pkt(input int sel0, input int len, input int sel_mid,
                            input int gap_max, input int abort_after, input bit seq);
        int dest;
        logic [DATA_W-1:0] data;
        dest = (sel0 >= 1 && sel0 <= N_CH) ? sel0 - 1 : -1;
        for (int b = 0; b < len; b++) begin
            if (abort_after > 0 && b == abort_after) return;
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    sel = SEL_W'($urandom);
                    step();
                end
            end
            if (b == 0) cur_dest = dest;
            data = seq ? DATA_W'((b + 1) * 17) : DATA_W'($urandom);
            send_beat(data, (b == len - 1),
                      (b == 0) ? sel0 : ((sel_mid >= 0) ? sel_mid : int'($urandom_range(0, 7))));
        end
        if (dest < 0) exp_drop_total++;
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();

        // Three-beat packet to channel 2 with 0x11/0x22/0x33.
        send_pkt(3, 3, -1, 0, 0, 1'b1);
        repeat (3) step();

        // Back-to-back packets, no gap, all consumers ready: no input stall.
        stalls = 0;
        send_pkt(1, 2, -1, 0, 0, 1'b0);
        send_pkt(5, 1, -1, 0, 0, 1'b0);
        send_pkt(4, 3, -1, 0, 0, 1'b0);
        check("b2b_stalls", stalls, 0);
        repeat (3) step();

        // Channel 1 stalls for 4 cycles mid-packet.
        fork
            send_pkt(2, 6, -1, 0, 0, 1'b0);
            begin
                repeat (2) step();
                hold_mask = 5'b00010;
                repeat (4) step();
                hold_mask = '0;
            end
        join
        repeat (3) step();

        // Invalid selects, mid-packet sel changes.
        send_pkt(0, 3, -1, 0, 0, 1'b0);
        send_pkt(6, 3, -1, 0, 0, 1'b0);
        send_pkt(3, 4, 4, 0, 0, 1'b0);
        repeat (3) step();

        // Reset after the 2nd of 4 beats, then a normal packet to channel 1.
        send_pkt(4, 4, -1, 0, 2, 1'b0);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        send_pkt(2, 3, -1, 0, 0, 1'b0);
        repeat (3) step();

        // Random traffic with random per-channel backpressure.
        rdy_random = 1'b1;
        for (int p = 0; p < 60; p++) begin
            send_pkt(int'($urandom_range(0, 7)), int'($urandom_range(1, 5)), -1, 2, 0, 1'b0);
        end
        rdy_random = 1'b0;
        repeat (10) step();

        for (int i = 0; i < N_CH; i++) begin
            check("drained_ch", exp_q[i].size(), 0);
        end
        check("drop_total", obs_drops, exp_drop_total);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
